// File: rtl/pwm_capture.sv
// Input-capture peripheral: measures period and high time of up to four pins in clk cycles
// and exposes the results over the simple read/write/address peripheral bus.
module pwm_capture #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                response,
  input  logic [CHANNELS-1:0] capture_in
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StMeas = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrStatus = 8'h04;
  localparam logic [7:0] AddrLevel  = 8'h08;

  logic [7:0] addr;
  logic       ctrl_we;
  logic       status_we;

  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] rise;

  logic [CHANNELS-1:0] ctrl_q, ctrl_d;
  logic [CHANNELS-1:0] valid_q, valid_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic [CHANNELS-1:0][1:0]           state_q, state_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] period_q, period_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] high_q, high_d;

  // Only address[7:0] and the low data bits are decoded.
  logic unused_bus;
  assign unused_bus = ^{address[31:8], write_data};

  assign addr      = address[7:0];
  assign ctrl_we   = write && (addr == AddrCtrl);
  assign status_we = write && (addr == AddrStatus);
  assign response  = read | write;

  // rise is seen on the third edge after the pin changes.
  assign rise = sync2_q & ~prev_q;

  always_comb begin
    sync1_d  = capture_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;

    if (ctrl_we) begin
      ctrl_d = write_data[CHANNELS-1:0];
    end
    // Software clear first so that hardware sets below override it.
    if (status_we) begin
      valid_d = valid_q & ~write_data[CHANNELS-1:0];
      ovf_d   = ovf_q & ~write_data[8 +: CHANNELS];
    end

    for (int n = 0; n < int'(CHANNELS); n++) begin
      if (!ctrl_q[n]) begin
        state_d[n] = StIdle;
        cnt_d[n]   = '0;
        hcnt_d[n]  = '0;
      end else begin
        unique case (state_q[n])
          StIdle: begin
            state_d[n] = StArm;
          end
          StArm: begin
            if (rise[n]) begin
              cnt_d[n]   = CntOne;
              hcnt_d[n]  = CntOne;
              state_d[n] = StMeas;
            end
          end
          StMeas: begin
            if (rise[n]) begin
              period_d[n] = cnt_q[n];
              high_d[n]   = hcnt_q[n];
              valid_d[n]  = 1'b1;
              cnt_d[n]    = CntOne;
              hcnt_d[n]   = CntOne;
            end else begin
              if (cnt_q[n] != CntMax) begin
                cnt_d[n] = cnt_q[n] + CntOne;
              end
              if (sync2_q[n] && (hcnt_q[n] != CntMax)) begin
                hcnt_d[n] = hcnt_q[n] + CntOne;
              end
            end
            if (cnt_q[n] == CntMax) begin
              ovf_d[n] = 1'b1;
            end
          end
          default: begin
            state_d[n] = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      ctrl_q   <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      state_q  <= '0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (read) begin
      if (addr == AddrCtrl) begin
        read_data[CHANNELS-1:0] = ctrl_q;
      end else if (addr == AddrStatus) begin
        read_data[CHANNELS-1:0]   = valid_q;
        read_data[8 +: CHANNELS]  = ovf_q;
      end else if (addr == AddrLevel) begin
        read_data[CHANNELS-1:0] = sync2_q;
      end
      for (int n = 0; n < int'(CHANNELS); n++) begin
        if (addr == 8'(16 + 8 * n)) begin
          read_data[CNT_WIDTH-1:0] = period_q[n];
        end
        if (addr == 8'(20 + 8 * n)) begin
          read_data[CNT_WIDTH-1:0] = high_q[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: register-map vector table plus hand-timed capture sequences
// on a 16-bit instance and an 8-bit instance for the saturation cases.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write, read8, write8;
  logic [31:0] address, write_data, read_data;
  logic [31:0] address8, write_data8, read_data8;
  logic        response, response8;
  logic [1:0]  pin, pin8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_capture #(.CHANNELS(2), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .response  (response),
    .capture_in(pin)
  );

  pwm_capture #(.CHANNELS(2), .CNT_WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .read      (read8),
    .write     (write8),
    .address   (address8),
    .write_data(write_data8),
    .read_data (read_data8),
    .response  (response8),
    .capture_in(pin8)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each bus access occupies exactly one clock edge.
  task automatic bus_write(input bit s8, input logic [7:0] a, input logic [31:0] d,
                           output logic resp);
    if (s8) begin
      write8 = 1'b1; address8 = {24'h0, a}; write_data8 = d;
    end else begin
      write = 1'b1; address = {24'hA5A5A5, a}; write_data = d;
    end
    #1;
    resp = s8 ? response8 : response;
    @(posedge clk);
    #1;
    write  = 1'b0;
    write8 = 1'b0;
  endtask

  task automatic bus_read(input bit s8, input logic [7:0] a, output logic [31:0] d,
                          output logic resp);
    if (s8) begin
      read8 = 1'b1; address8 = {24'h0, a};
    end else begin
      read = 1'b1; address = {24'hA5A5A5, a};
    end
    #1;
    d    = s8 ? read_data8 : read_data;
    resp = s8 ? response8 : response;
    read  = 1'b0;
    read8 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input bit s8, input string name, input logic [7:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    bus_read(s8, a, d, r);
    check(name, d, exp);
  endtask

  task automatic wr(input bit s8, input logic [7:0] a, input logic [31:0] d);
    logic r;
    bus_write(s8, a, d, r);
  endtask

  task automatic pwm(input int high, input int low);
    pin[0] = 1'b1;
    wait_cycles(high);
    pin[0] = 1'b0;
    wait_cycles(low);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        r;
    logic [7:0]  rst_addrs [5];

    vecs[0]  = '{1'b0, 8'h00, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 8'h10, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 8'h14, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, 8'h00, 32'h0, 32'h3};
    vecs[7]  = '{1'b1, 8'h08, 32'hFF, 32'h0};
    vecs[8]  = '{1'b0, 8'h08, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 8'h10, 32'h1234, 32'h0};
    vecs[10] = '{1'b0, 8'h10, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 8'h0C, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 8'h20, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 8'h11, 32'h0, 32'h0};
    vecs[14] = '{1'b1, 8'h40, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{1'b1, 8'h00, 32'h0, 32'h0};
    vecs[16] = '{1'b0, 8'h00, 32'h0, 32'h0};

    reset = 1'b1;
    read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    read8 = 1'b0; write8 = 1'b0; address8 = '0; write_data8 = '0;
    pin = '0; pin8 = '0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);

    check("idle_response", {31'h0, response}, 32'h0);
    check("idle_read_data", read_data, 32'h0);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        bus_write(1'b0, vecs[i].addr, vecs[i].wdata, r);
        check($sformatf("vec[%0d]_wr_response", i), {31'h0, r}, 32'h1);
      end else begin
        bus_read(1'b0, vecs[i].addr, d, r);
        check($sformatf("vec[%0d]_rd_response", i), {31'h0, r}, 32'h1);
        check($sformatf("vec[%0d]_rd_data", i), d, vecs[i].exp);
      end
    end

    // Basic measurement: period 100, high 25.
    wr(1'b0, 8'h00, 32'h3);
    wait_cycles(3);
    pwm(25, 75);
    pwm(25, 75);
    rd_check(1'b0, "period0", 8'h10, 32'd100);
    rd_check(1'b0, "high0", 8'h14, 32'd25);
    rd_check(1'b0, "status_valid0", 8'h04, 32'h1);
    rd_check(1'b0, "level_low", 8'h08, 32'h0);
    wr(1'b0, 8'h04, 32'h1);
    rd_check(1'b0, "status_w1c", 8'h04, 32'h0);

    // W1C lands on the same edge as the latching rise; period is 106 by cycle count.
    pin[0] = 1'b1;
    wait_cycles(2);
    wr(1'b0, 8'h04, 32'h1);
    rd_check(1'b0, "status_set_wins", 8'h04, 32'h1);
    rd_check(1'b0, "period0_after_reads", 8'h10, 32'd106);
    rd_check(1'b0, "level_high", 8'h08, 32'h1);
    wait_cycles(8);
    pin[0] = 1'b0;
    wr(1'b0, 8'h04, 32'h1);
    rd_check(1'b0, "status_cleared", 8'h04, 32'h0);

    // Disable mid-period, re-enable: first rise only arms.
    wr(1'b0, 8'h00, 32'h0);
    wr(1'b0, 8'h00, 32'h1);
    wait_cycles(3);
    pin[0] = 1'b1;
    wait_cycles(20);
    pin[0] = 1'b0;
    wait_cycles(30);
    rd_check(1'b0, "period0_retained", 8'h10, 32'd106);
    rd_check(1'b0, "status_no_latch_on_arm", 8'h04, 32'h0);
    wait_cycles(8);
    pin[0] = 1'b1;
    wait_cycles(20);
    pin[0] = 1'b0;
    wait_cycles(10);
    rd_check(1'b0, "period0_rearmed", 8'h10, 32'd60);
    rd_check(1'b0, "high0_rearmed", 8'h14, 32'd20);
    rd_check(1'b0, "status_rearmed", 8'h04, 32'h1);

    read = 1'b0;
    address = 32'h10;
    #1;
    check("read_data_no_read", read_data, 32'h0);
    check("response_no_access", {31'h0, response}, 32'h0);
    wait_cycles(1);

    // 8-bit instance: constant-low ch0, then ch0 held high and ch1 with a 301-cycle period.
    wr(1'b1, 8'h00, 32'h3);
    wait_cycles(20);
    rd_check(1'b1, "w8_high0_const0", 8'h14, 32'h0);
    rd_check(1'b1, "w8_status_const0", 8'h04, 32'h0);
    pin8 = 2'b11;
    wait_cycles(1);
    pin8[1] = 1'b0;
    wait_cycles(300);
    pin8[1] = 1'b1;
    wait_cycles(1);
    pin8[1] = 1'b0;
    wait_cycles(5);
    rd_check(1'b1, "w8_status_ovf", 8'h04, 32'h302);
    rd_check(1'b1, "w8_period1_sat", 8'h18, 32'hFF);
    rd_check(1'b1, "w8_high1", 8'h1C, 32'h1);
    rd_check(1'b1, "w8_period0_const1", 8'h10, 32'h0);
    rd_check(1'b1, "w8_high0_const1", 8'h14, 32'h0);
    rd_check(1'b1, "w8_level", 8'h08, 32'h1);
    wr(1'b1, 8'h04, 32'h300);
    rd_check(1'b1, "w8_ovf_w1c", 8'h04, 32'h102);

    // Reset in the middle of a measurement clears everything.
    pin[0] = 1'b1;
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    pin[0] = 1'b0;
    wait_cycles(3);
    rst_addrs[0] = 8'h00;
    rst_addrs[1] = 8'h04;
    rst_addrs[2] = 8'h08;
    rst_addrs[3] = 8'h10;
    rst_addrs[4] = 8'h14;
    for (int i = 0; i < 5; i++) begin
      rd_check(1'b0, $sformatf("after_reset_0x%02h", rst_addrs[i]), rst_addrs[i], 32'h0);
    end
    rd_check(1'b1, "w8_status_after_reset", 8'h04, 32'h0);
    check("read_data_after_reset", read_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
